// File: rtl/tdc_frame_tx_if.sv
// Capture-side and serial-side signals of the TDC frame transmitter.
// The master modport drives samples; the slave modport is the transmitter.
interface tdc_frame_tx_if;
   logic [7:0] tdc_i;
   logic       sample_i;
   logic       clear_ovf_i;
   logic       tx_o;
   logic       busy_o;
   logic       overflow_o;
   logic [2:0] fifo_level_o;

   modport master (
      output tdc_i, sample_i, clear_ovf_i,
      input  tx_o, busy_o, overflow_o, fifo_level_o
   );

   modport slave (
      input  tdc_i, sample_i, clear_ovf_i,
      output tx_o, busy_o, overflow_o, fifo_level_o
   );
endinterface

// File: rtl/tdc_frame_tx.sv
// TDC readout: thermometer decode, small FIFO and UART-style serializer.
// Frame byte is {bubble, 3'b000, count}; serial bits go out LSB first.
module tdc_frame_tx #(
   parameter int TDC_WIDTH    = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int CLKS_PER_BIT = 16
) (
   input logic clk,
   input logic rst_n,
   tdc_frame_tx_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state;
   logic [TDC_WIDTH-1:0]   cap_q;
   logic                   cap_v;
   logic [7:0]             mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [3:0]             level;
   logic [CW-1:0]          baud;
   logic [2:0]             bit_idx;
   logic [7:0]             shreg;
   logic                   tx_q;
   logic                   busy_q;
   logic                   ovf_q;

   logic [3:0] ones;
   logic [8:0] therm;
   logic       bubble;
   logic [7:0] frame_byte;
   logic       pop;
   logic       full;
   logic       push;
   logic       drop;
   logic       bit_end;

   always_comb begin
      ones = 4'd0;
      for (int i = 0; i < TDC_WIDTH; i++)
         ones = ones + {3'b000, cap_q[i]};
      therm      = (9'd1 << ones) - 9'd1;
      bubble     = (cap_q != therm[7:0]);
      frame_byte = {bubble, 3'b000, ones};
   end

   assign pop     = (state == IDLE) && (level != 4'd0);
   assign full    = (level == 4'(FIFO_DEPTH));
   // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
   assign push    = cap_v && (!full || pop);
   assign drop    = cap_v && !push;
   assign bit_end = (baud == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_q <= '0;
         cap_v <= 1'b0;
      end else begin
         cap_v <= bus.sample_i;
         if (bus.sample_i)
            cap_q <= bus.tdc_i;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= frame_byte;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= 4'd0;
         ovf_q  <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            level <= level + 4'd1;
         else if (pop && !push)
            level <= level - 4'd1;
         if (drop)
            ovf_q <= 1'b1;
         else if (bus.clear_ovf_i)
            ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= 3'd0;
         shreg   <= 8'd0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               tx_q <= 1'b1;
               if (pop) begin
                  shreg   <= mem[rd_ptr];
                  baud    <= '0;
                  bit_idx <= 3'd0;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= START;
               end
            end
            START: begin
               baud <= baud + 1'b1;
               if (bit_end) begin
                  baud  <= '0;
                  tx_q  <= shreg[0];
                  state <= DATA;
               end
            end
            DATA: begin
               baud <= baud + 1'b1;
               if (bit_end) begin
                  baud <= '0;
                  if (bit_idx == 3'd7) begin
                     tx_q  <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= shreg >> 1;
                     tx_q    <= shreg[1];
                  end
               end
            end
            STOP: begin
               baud <= baud + 1'b1;
               if (bit_end) begin
                  baud   <= '0;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.tx_o         = tx_q;
   assign bus.busy_o       = busy_q;
   assign bus.overflow_o   = ovf_q;
   assign bus.fifo_level_o = level[2:0];
endmodule

// File: tb/tb_tdc_frame_tx.sv
// Directed bench for tdc_frame_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// One task per scenario; each task compares outputs against hand values.
module tb_tdc_frame_tx;
   localparam int CPB = 4;
   localparam int FL  = 10 * CPB;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   tdc_frame_tx_if bus ();

   tdc_frame_tx #(
      .TDC_WIDTH   (8),
      .FIFO_DEPTH  (4),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_bit(input logic [7:0] b, input int p);
      int  k;
      logic [7:0] v;
      k = p / CPB;
      v = b;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return v[k-1];
   endfunction

   task automatic test_reset();
      rst_n           = 1'b0;
      bus.tdc_i       = 8'h00;
      bus.sample_i    = 1'b0;
      bus.clear_ovf_i = 1'b0;
      #12;
      checks++;
      if (bus.tx_o !== 1'b1 || bus.busy_o !== 1'b0 ||
          bus.overflow_o !== 1'b0 || bus.fifo_level_o !== 3'd0) begin
         errors++;
         $display("FAIL reset_hold got tx=%b busy=%b ovf=%b lvl=%0d exp 1 0 0 0",
                  bus.tx_o, bus.busy_o, bus.overflow_o, bus.fifo_level_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         checks++;
         if (bus.tx_o !== 1'b1 || bus.busy_o !== 1'b0 ||
             bus.overflow_o !== 1'b0 || bus.fifo_level_o !== 3'd0) begin
            errors++;
            $display("FAIL idle_%0d got tx=%b busy=%b ovf=%b lvl=%0d exp 1 0 0 0",
                     i, bus.tx_o, bus.busy_o, bus.overflow_o, bus.fifo_level_o);
         end
      end
   endtask

   task automatic test_frame(input logic [7:0] word, input logic [7:0] exp_b);
      bus.tdc_i    = word;
      bus.sample_i = 1'b1;
      step();
      bus.sample_i = 1'b0;
      bus.tdc_i    = 8'hA5;
      step();
      checks++;
      if (bus.fifo_level_o !== 3'd1 || bus.busy_o !== 1'b0 || bus.tx_o !== 1'b1) begin
         errors++;
         $display("FAIL e1_%h got lvl=%0d busy=%b tx=%b exp 1 0 1",
                  word, bus.fifo_level_o, bus.busy_o, bus.tx_o);
      end
      step();
      checks++;
      if (bus.fifo_level_o !== 3'd0) begin
         errors++;
         $display("FAIL pop_%h got lvl=%0d exp 0", word, bus.fifo_level_o);
      end
      for (int p = 0; p < FL; p++) begin
         checks++;
         if (bus.tx_o !== exp_bit(exp_b, p) || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL frame_%h_p%0d got tx=%b busy=%b exp %b 1",
                     word, p, bus.tx_o, bus.busy_o, exp_bit(exp_b, p));
         end
         step();
      end
      checks++;
      if (bus.tx_o !== 1'b1 || bus.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL end_%h got tx=%b busy=%b exp 1 0",
                  word, bus.tx_o, bus.busy_o);
      end
      repeat (3) step();
   endtask

   task automatic test_burst();
      logic [7:0] words [6];
      logic [7:0] bytes [5];
      int f;
      int p;
      words = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F};
      bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      bus.tdc_i    = words[0];
      bus.sample_i = 1'b1;
      step();
      bus.tdc_i = words[1];
      step();
      checks++;
      if (bus.fifo_level_o !== 3'd1) begin
         errors++;
         $display("FAIL burst_e1 got lvl=%0d exp 1", bus.fifo_level_o);
      end
      bus.tdc_i = words[2];
      step();
      for (int n = 0; n < 5 * (FL + 1) + 20; n++) begin
         f = n / (FL + 1);
         p = n % (FL + 1);
         if (n == 0) bus.tdc_i = words[3];
         if (n == 1) bus.tdc_i = words[4];
         if (n == 2) bus.tdc_i = words[5];
         if (n == 3) begin
            bus.sample_i    = 1'b0;
            bus.clear_ovf_i = 1'b1;
         end
         if (n == 5) bus.clear_ovf_i = 1'b0;
         if (n <= 4) begin
            checks++;
            if (bus.fifo_level_o !== 3'(n < 4 ? n + 1 : 4)) begin
               errors++;
               $display("FAIL burst_lvl_n%0d got %0d exp %0d",
                        n, bus.fifo_level_o, (n < 4 ? n + 1 : 4));
            end
         end
         if (n >= 3 && n <= 5) begin
            checks++;
            if (bus.overflow_o !== (n == 4)) begin
               errors++;
               $display("FAIL burst_ovf_n%0d got %b exp %b",
                        n, bus.overflow_o, (n == 4));
            end
         end
         checks++;
         if (f < 5 && p < FL) begin
            if (bus.tx_o !== exp_bit(bytes[f], p) || bus.busy_o !== 1'b1) begin
               errors++;
               $display("FAIL burst_f%0d_p%0d got tx=%b busy=%b exp %b 1",
                        f, p, bus.tx_o, bus.busy_o, exp_bit(bytes[f], p));
            end
         end else begin
            if (bus.tx_o !== 1'b1 || bus.busy_o !== 1'b0) begin
               errors++;
               $display("FAIL burst_gap_n%0d got tx=%b busy=%b exp 1 0",
                        n, bus.tx_o, bus.busy_o);
            end
         end
         step();
      end
      checks++;
      if (bus.fifo_level_o !== 3'd0) begin
         errors++;
         $display("FAIL burst_drain got lvl=%0d exp 0", bus.fifo_level_o);
      end
   endtask

   task automatic test_reset_mid();
      bus.tdc_i    = 8'h0F;
      bus.sample_i = 1'b1;
      step();
      step();
      bus.sample_i = 1'b0;
      step();
      repeat (17) step();
      checks++;
      if (bus.tx_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.fifo_level_o !== 3'd1) begin
         errors++;
         $display("FAIL pre_rst got tx=%b busy=%b lvl=%0d exp 0 1 1",
                  bus.tx_o, bus.busy_o, bus.fifo_level_o);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.tx_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.fifo_level_o !== 3'd0) begin
         errors++;
         $display("FAIL async_rst got tx=%b busy=%b lvl=%0d exp 1 0 0",
                  bus.tx_o, bus.busy_o, bus.fifo_level_o);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step();
         checks++;
         if (bus.tx_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.fifo_level_o !== 3'd0) begin
            errors++;
            $display("FAIL post_rst_%0d got tx=%b busy=%b lvl=%0d exp 1 0 0",
                     i, bus.tx_o, bus.busy_o, bus.fifo_level_o);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_frame(8'h0F, 8'h04);
      test_frame(8'h0B, 8'h83);
      test_frame(8'hFF, 8'h08);
      test_frame(8'h00, 8'h00);
      test_burst();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
